uart_rx_oversample: RTL

//   UART receive path, the counterpart to the transmitter in customUartTop. It

---
 rtl/uart_rx_oversample.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver, 16x oversampling with 3-sample majority vote
module uart_rx_oversample #(
    parameter int SYSTEM_CLOCK  = 100000000,
    parameter int UART_BAUDRATE = 115200,
    parameter int OVERSAMPLE    = 16
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rx_complete,
    output logic       rx_valid,
    output logic [1:0] rx_error_bit,
    output logic       deb_rx,
    output logic       deb_rx_clk
);

    // Rounded divider from system clock to the oversample tick rate.
    localparam int DIV = (SYSTEM_CLOCK + UART_BAUDRATE * (OVERSAMPLE / 2)) / (UART_BAUDRATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    dout_q, dout_d;
    logic          cmpl_q, cmpl_d;
    logic          valid_q, valid_d;
    logic [1:0]    err_q, err_d;
    logic          armed_q, armed_d;
    logic          tick;
    logic          maj;

    assign tick = (div_q == DW'(DIV - 1));
    // Third vote is the live synchronised sample taken at tcnt 9.
    assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);

    assign dout         = dout_q;
    assign rx_complete  = cmpl_q;
    assign rx_valid     = valid_q;
    assign rx_error_bit = err_q;
    assign deb_rx       = sync2_q;
    assign deb_rx_clk   = tick;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: tick divider, per-bit tick count, frame FSM and read handshake.
    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        tcnt_d   = tcnt_q;
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        samp_d   = samp_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        cmpl_d   = 1'b0;
        valid_d  = valid_q;
        err_d    = err_q;
        armed_d  = armed_q;

        if (state_q != S_IDLE && tick) begin
            tcnt_d = tcnt_q + 4'd1;
            if (tcnt_q == 4'd7) samp_d[0] = sync2_q;
            if (tcnt_q == 4'd8) samp_d[1] = sync2_q;
        end

        if (rd_en && valid_q) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tcnt_d = 4'd0;
                // armed only after a high level, so a stuck-low line never restarts.
                if (armed_q && !sync2_q) begin
                    state_d = S_START;
                    div_d   = '0;
                    armed_d = 1'b0;
                end else if (sync2_q) begin
                    armed_d = 1'b1;
                end
            end
            S_START: begin
                if (tick && tcnt_q == 4'd9 && maj) begin
                    state_d = S_IDLE;
                end else if (tick && tcnt_q == 4'd15) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick && tcnt_q == 4'd9) shreg_d = {maj, shreg_q[7:1]};
                if (tick && tcnt_q == 4'd15) begin
                    if (bitcnt_q == 3'd7) state_d = S_STOP;
                    else                  bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            default: begin
                // Finish at mid-stop to leave margin for baud-rate mismatch.
                if (tick && tcnt_q == 4'd9) begin
                    state_d = S_IDLE;
                    dout_d  = shreg_q;
                    cmpl_d  = 1'b1;
                    valid_d = 1'b1;
                    // A same-cycle read consumes the old byte, so no overrun.
                    err_d   = {valid_q & ~rd_en, ~maj};
                end
            end
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            tcnt_q   <= 4'd0;
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            samp_q   <= 2'b11;
            shreg_q  <= 8'd0;
            dout_q   <= 8'd0;
            cmpl_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            samp_q   <= samp_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            cmpl_q   <= cmpl_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            armed_q  <= armed_d;
        end
    end

endmodule
